ltl_nfa_monitor: RTL and testbench

Parametrised, runtime-programmable homogeneous NFA engine for LTL instruction-pair monitoring. It replaces per-property generated automata with one engine of NUM_STE state elements, each configured at run time with an interval, predecessor mask, start type and report flag. It sits beside the commit stage, consumes one encoded symbol per accepted handshake, and raises report/violation indications to the monitor aggregator.

---
 rtl/ltl_mon_pkg.sv | 14 +
 rtl/ltl_mon_ste_cell.sv | 29 ++
 rtl/ltl_nfa_monitor.sv | 100 ++++++++++
 tb/tb_ltl_nfa_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// ltl_mon_pkg: shared types and limits for the LTL NFA monitor
package ltl_mon_pkg;
  localparam int NUM_STE_MAX = 64;
  localparam int SYM_W_MAX = 32;
  typedef enum logic [1:0] {NONE = 2'd0, SOD = 2'd1, ALL = 2'd2} start_type_e;
  typedef struct packed {
    logic [SYM_W_MAX-1:0]   lo;
    logic [SYM_W_MAX-1:0]   hi;
    logic [NUM_STE_MAX-1:0] pred;
    start_type_e            start;
    logic                   report;
  } ste_cfg_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mon_state_e;
endpackage

// File: rtl/ltl_mon_ste_cell.sv
// ltl_mon_ste_cell: one state element with its config entry, interval match and active flop
module ltl_mon_ste_cell
  import ltl_mon_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  ste_cfg_t               cfg_in,
  input  logic                   clr,
  input  logic                   accept,
  input  logic                   first,
  input  logic [SYM_W_MAX-1:0]   sym,
  input  logic [NUM_STE_MAX-1:0] active_vec,
  output logic                   active,
  output logic                   report
);
  ste_cfg_t cfg;
  logic en;
  assign en = (cfg.start == SOD && first) || cfg.start == ALL || |(active_vec & cfg.pred);
  assign report = cfg.report;
  // config entry: cleared by reset so the element is unreachable until programmed
  always_ff @(posedge clk)
    if (reset) cfg <= '0;
    else if (cfg_we) cfg <= cfg_in;
  // active flop: advances only on an accepted symbol, cleared at trace boundaries
  always_ff @(posedge clk)
    if (reset || clr) active <= 1'b0;
    else if (accept) active <= en && sym >= cfg.lo && sym <= cfg.hi;
endmodule

// File: rtl/ltl_nfa_monitor.sv
// ltl_nfa_monitor: runtime-programmable NFA engine for LTL monitoring; LTL_MON_FIRST_REPORT_EN enables violation/first_idx capture
module ltl_nfa_monitor
  import ltl_mon_pkg::*;
#(
  parameter int NUM_STE = 16,
  parameter int SYM_W   = 8,
  parameter int IDX_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_STE)-1:0] cfg_idx,
  input  logic [SYM_W-1:0]           cfg_lo,
  input  logic [SYM_W-1:0]           cfg_hi,
  input  logic [NUM_STE-1:0]         cfg_pred,
  input  logic [1:0]                 cfg_start,
  input  logic                       cfg_report,
  output logic                       cfg_err,
  input  logic                       trace_start,
  input  logic                       trace_end,
  input  logic                       sym_valid,
  input  logic [SYM_W-1:0]           sym,
  output logic                       sym_ready,
  output logic [NUM_STE-1:0]         active,
  output logic                       report_valid,
  output logic [NUM_STE-1:0]         report_vec,
  output logic [IDX_W-1:0]           report_idx,
  output logic                       violation,
  output logic [IDX_W-1:0]           first_idx
);
  localparam int CW = $clog2(NUM_STE);
  mon_state_e state, state_nxt;
  logic [IDX_W-1:0] sym_idx;
  logic first, accept, start_go, clr;
  logic [NUM_STE-1:0] report_mask;
  logic [NUM_STE_MAX-1:0] active_ext;
  ste_cfg_t cfg_in;
  assign start_go = trace_start & ~trace_end;
  assign clr = trace_start | trace_end;
  assign sym_ready = state == RUN;
  // a symbol arriving with a trace boundary belongs to neither trace and is dropped
  assign accept = sym_valid & sym_ready & ~clr;
  assign active_ext = NUM_STE_MAX'(active);
  assign cfg_in = '{lo: SYM_W_MAX'(cfg_lo), hi: SYM_W_MAX'(cfg_hi), pred: NUM_STE_MAX'(cfg_pred),
                    start: start_type_e'(cfg_start), report: cfg_report};
  assign report_vec = active & report_mask;
  assign report_valid = |report_vec;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  // next state: trace_end beats a simultaneous trace_start
  always_comb
    state_nxt = trace_end ? IDLE : trace_start ? RUN : state;
  // config writes are only legal while idle
  always_ff @(posedge clk)
    cfg_err <= !reset && cfg_we && state == RUN;
  // symbol index, first-symbol flag and index of the symbol behind the current report
  always_ff @(posedge clk)
    if (reset) begin
      sym_idx <= '0;
      first <= 1'b0;
      report_idx <= '0;
    end else if (start_go) begin
      sym_idx <= '0;
      first <= 1'b1;
    end else if (accept) begin
      report_idx <= sym_idx;
      first <= 1'b0;
      sym_idx <= &sym_idx ? sym_idx : sym_idx + 1'b1;
    end
  for (genvar i = 0; i < NUM_STE; i++) begin : g_ste
    ltl_mon_ste_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we && state == IDLE && cfg_idx == CW'(i)),
      .cfg_in     (cfg_in),
      .clr        (clr),
      .accept     (accept),
      .first      (first),
      .sym        (SYM_W_MAX'(sym)),
      .active_vec (active_ext),
      .active     (active[i]),
      .report     (report_mask[i])
    );
  end
`ifdef LTL_MON_FIRST_REPORT_EN
  // latch the first report of the trace and the index that caused it
  always_ff @(posedge clk)
    if (reset || start_go) begin
      violation <= 1'b0;
      first_idx <= '0;
    end else if (report_valid && !violation) begin
      violation <= 1'b1;
      first_idx <= report_idx;
    end
`else
  assign violation = 1'b0;
  assign first_idx = '0;
`endif
endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// tb_ltl_nfa_monitor: scoreboard bench for ltl_nfa_monitor (4 STEs, 4-bit index)
module tb_ltl_nfa_monitor;
`ifdef LTL_MON_FIRST_REPORT_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, cfg_report = 1'b0;
  logic [1:0] cfg_idx = '0, cfg_start = '0;
  logic [7:0] cfg_lo = '0, cfg_hi = '0, sym = '0;
  logic [3:0] cfg_pred = '0;
  logic trace_start = 1'b0, trace_end = 1'b0, sym_valid = 1'b0;
  logic cfg_err, sym_ready, report_valid, violation;
  logic [3:0] active, report_vec, report_idx, first_idx;
  int checks = 0, failures = 0;
  typedef struct packed {logic valid; logic [3:0] vec; logic [3:0] idx;} exp_t;
  exp_t sb[$];
  logic [7:0] m_lo[4], m_hi[4];
  logic [3:0] m_pred[4];
  logic [1:0] m_start[4];
  logic [3:0] m_rep, m_act, m_idx, m_fidx;
  logic m_first, m_run, m_viol;

  ltl_nfa_monitor #(.NUM_STE(4), .SYM_W(8), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi), .cfg_pred(cfg_pred), .cfg_start(cfg_start), .cfg_report(cfg_report),
    .cfg_err(cfg_err), .trace_start(trace_start), .trace_end(trace_end),
    .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready), .active(active),
    .report_valid(report_valid), .report_vec(report_vec), .report_idx(report_idx),
    .violation(violation), .first_idx(first_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_lo[i] = '0; m_hi[i] = '0; m_pred[i] = '0; m_start[i] = '0;
    end
    m_rep = '0; m_act = '0; m_idx = '0; m_fidx = '0;
    m_first = 1'b0; m_run = 1'b0; m_viol = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [3:0] pred, input logic [1:0] st, input logic rep);
    cfg_we = 1'b1; cfg_idx = idx; cfg_lo = lo; cfg_hi = hi; cfg_pred = pred;
    cfg_start = st; cfg_report = rep;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== m_run) begin
      failures++;
      $display("FAIL cfg_err_set got=%b want=%b", cfg_err, m_run);
    end
    if (!m_run) begin
      m_lo[idx] = lo; m_hi[idx] = hi; m_pred[idx] = pred; m_start[idx] = st; m_rep[idx] = rep;
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err_pulse got=%b want=0", cfg_err);
    end
  endtask

  task automatic start_trace();
    trace_start = 1'b1;
    tick();
    trace_start = 1'b0;
    m_act = '0; m_idx = '0; m_first = 1'b1; m_viol = 1'b0; m_fidx = '0; m_run = 1'b1;
    checks++;
    if (sym_ready !== 1'b1 || active !== 4'b0) begin
      failures++;
      $display("FAIL trace_start ready=%b active=%b want ready=1 active=0000", sym_ready, active);
    end
  endtask

  task automatic end_trace();
    trace_end = 1'b1;
    tick();
    trace_end = 1'b0;
    m_act = '0; m_run = 1'b0;
    checks++;
    if (sym_ready !== 1'b0 || active !== 4'b0 || violation !== (CAP & m_viol) ||
        first_idx !== (CAP ? m_fidx : 4'd0)) begin
      failures++;
      $display("FAIL trace_end ready=%b active=%b viol=%b fidx=%0d want ready=0 active=0000 viol=%b fidx=%0d",
               sym_ready, active, violation, first_idx, CAP & m_viol, CAP ? m_fidx : 4'd0);
    end
  endtask

  task automatic send(input logic [7:0] s);
    exp_t e, g;
    logic [3:0] na;
    for (int i = 0; i < 4; i++) begin
      logic en;
      en = (m_start[i] == 2'd1 && m_first) || m_start[i] == 2'd2 || |(m_act & m_pred[i]);
      na[i] = en && s >= m_lo[i] && s <= m_hi[i];
    end
    e.vec = na & m_rep;
    e.valid = |e.vec;
    e.idx = m_idx;
    sb.push_back(e);
    m_act = na;
    m_first = 1'b0;
    m_idx = (m_idx == 4'd15) ? m_idx : m_idx + 4'd1;
    sym_valid = 1'b1; sym = s;
    tick();
    sym_valid = 1'b0;
    g = sb.pop_front();
    checks++;
    if (report_valid !== g.valid || report_vec !== g.vec) begin
      failures++;
      $display("FAIL report sym=%0d got valid=%b vec=%b want valid=%b vec=%b", s, report_valid, report_vec, g.valid, g.vec);
    end
    checks++;
    if (report_idx !== g.idx && g.valid) begin
      failures++;
      $display("FAIL report_idx sym=%0d got=%0d want=%0d", s, report_idx, g.idx);
    end
    checks++;
    if (active !== m_act) begin
      failures++;
      $display("FAIL active sym=%0d got=%b want=%b", s, active, m_act);
    end
    if (g.valid && !m_viol) begin
      m_viol = 1'b1;
      m_fidx = g.idx;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_reset();
    checks++;
    if ({active, report_valid, report_vec, report_idx, violation, first_idx, cfg_err, sym_ready} !== '0) begin
      failures++;
      $display("FAIL reset_values active=%b rv=%b vec=%b ridx=%0d viol=%b fidx=%0d err=%b rdy=%b want all 0",
               active, report_valid, report_vec, report_idx, violation, first_idx, cfg_err, sym_ready);
    end
  endtask

  task automatic test_lw_lw();
    cfg_write(2'd0, 8'd0, 8'd63, 4'b0001, 2'd1, 1'b0);
    cfg_write(2'd1, 8'd64, 8'd255, 4'b0001, 2'd0, 1'b1);
    cfg_write(2'd2, 8'd0, 8'd0, 4'b0000, 2'd0, 1'b0);
    cfg_write(2'd3, 8'd0, 8'd0, 4'b0000, 2'd0, 1'b0);
    start_trace();
    send(8'd10);
    send(8'd20);
    checks++;
    if (report_valid !== 1'b0) begin
      failures++;
      $display("FAIL lw_lw_early got valid=%b want 0", report_valid);
    end
    send(8'd100);
    checks++;
    if (report_valid !== 1'b1 || report_idx !== 4'd2 || report_vec !== 4'b0010) begin
      failures++;
      $display("FAIL lw_lw_report got valid=%b idx=%0d vec=%b want 1 2 0010", report_valid, report_idx, report_vec);
    end
    end_trace();
  endtask

  task automatic test_all_input();
    cfg_write(2'd0, 8'd5, 8'd5, 4'b0000, 2'd2, 1'b1);
    cfg_write(2'd1, 8'd0, 8'd0, 4'b0000, 2'd0, 1'b0);
    start_trace();
    send(8'd1);
    send(8'd5);
    send(8'd7);
    send(8'd5);
    end_trace();
    checks++;
    if (first_idx !== (CAP ? 4'd1 : 4'd0) || violation !== CAP) begin
      failures++;
      $display("FAIL all_input_first got viol=%b fidx=%0d want %b %0d", violation, first_idx, CAP, CAP ? 1 : 0);
    end
  endtask

  task automatic test_cfg_in_run();
    start_trace();
    cfg_write(2'd0, 8'd0, 8'd255, 4'b0000, 2'd2, 1'b1);
    send(8'd7);
    send(8'd5);
    end_trace();
    start_trace();
    send(8'd9);
    send(8'd5);
    end_trace();
  endtask

  task automatic test_start_end();
    start_trace();
    send(8'd5);
    trace_start = 1'b1; trace_end = 1'b1;
    tick();
    trace_start = 1'b0; trace_end = 1'b0;
    m_act = '0; m_run = 1'b0;
    checks++;
    if (sym_ready !== 1'b0 || active !== 4'b0 || report_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_end got ready=%b active=%b rv=%b want 0 0000 0", sym_ready, active, report_valid);
    end
    checks++;
    if (violation !== CAP || first_idx !== 4'd0) begin
      failures++;
      $display("FAIL start_end_viol got viol=%b fidx=%0d want %b 0", violation, first_idx, CAP);
    end
  endtask

  task automatic test_back_to_back_saturation();
    cfg_write(2'd0, 8'd0, 8'd255, 4'b0000, 2'd2, 1'b1);
    start_trace();
    for (int k = 0; k < 20; k++) send(8'(k * 13));
    checks++;
    if (report_idx !== 4'd15 || report_valid !== 1'b1) begin
      failures++;
      $display("FAIL saturation got idx=%0d valid=%b want 15 1", report_idx, report_valid);
    end
    end_trace();
  endtask

  task automatic test_reset_mid_trace();
    cfg_write(2'd2, 8'd1, 8'd1, 4'b0000, 2'd2, 1'b1);
    start_trace();
    send(8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    checks++;
    if ({active, report_valid, report_vec, report_idx, violation, first_idx, cfg_err, sym_ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid active=%b rv=%b vec=%b ridx=%0d viol=%b fidx=%0d err=%b rdy=%b want all 0",
               active, report_valid, report_vec, report_idx, violation, first_idx, cfg_err, sym_ready);
    end
    start_trace();
    send(8'd0);
    send(8'd1);
    send(8'd255);
    end_trace();
  endtask

  initial begin
    test_reset();
    test_lw_lw();
    test_all_input();
    test_cfg_in_run();
    test_start_end();
    test_back_to_back_saturation();
    test_reset_mid_trace();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
